// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } requester_t;

    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts granted cycles without a memory response and flags
// when the configured limit is reached.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] ONE   = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count_r;

    // Wait-cycle counter, cleared whenever no grant is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// alternating tie-break and a watchdog that force-completes stalled grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_read,
    input  logic [31:0] inst_address,
    output logic [31:0] inst_rdata,
    output logic        inst_resp,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_wmask,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout_err
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    requester_t last_served_r;
    requester_t last_served_nxt_s;
    logic       timeout_err_r;
    logic       set_err_s;
    logic       data_req_s;
    logic       expired_s;
    logic       wd_clear_s;
    logic       wd_enable_s;

    assign data_req_s  = data_read | data_write;
    assign wd_clear_s  = (state_r == IDLE);
    assign wd_enable_s = (state_r != IDLE) & ~mem_resp;
    assign timeout_err = timeout_err_r;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear_s),
        .enable (wd_enable_s),
        .expired(expired_s)
    );

    // State, fairness pointer and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            last_served_r <= REQ_INST;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            last_served_r <= last_served_nxt_s;
            timeout_err_r <= timeout_err_r | set_err_s;
        end
    end

    // Next-state, memory-port muxing and response generation
    always_comb begin
        state_nxt_s       = state_r;
        last_served_nxt_s = last_served_r;
        set_err_s         = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_byte_enable   = 4'b0000;
        mem_address       = 32'h0000_0000;
        mem_wdata         = 32'h0000_0000;
        inst_resp         = 1'b0;
        inst_rdata        = 32'h0000_0000;
        data_resp         = 1'b0;
        data_rdata        = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (inst_read && data_req_s) begin
                    state_nxt_s = (last_served_r == REQ_INST) ? DATA : INST;
                end else if (inst_read) begin
                    state_nxt_s = INST;
                end else if (data_req_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INST: begin
                mem_read    = 1'b1;
                mem_address = inst_address;
                // A withdrawn request aborts silently, even if memory answers now
                if (!inst_read) begin
                    state_nxt_s = IDLE;
                end else if (mem_resp) begin
                    inst_resp         = 1'b1;
                    inst_rdata        = mem_rdata;
                    last_served_nxt_s = REQ_INST;
                    state_nxt_s       = IDLE;
                end else if (expired_s) begin
                    inst_resp         = 1'b1;
                    set_err_s         = 1'b1;
                    last_served_nxt_s = REQ_INST;
                    state_nxt_s       = IDLE;
                end else begin
                    state_nxt_s = INST;
                end
            end
            DATA: begin
                mem_read        = data_read & ~data_write;
                mem_write       = data_write;
                mem_byte_enable = data_wmask;
                mem_address     = data_address;
                mem_wdata       = data_wdata;
                if (!data_req_s) begin
                    state_nxt_s = IDLE;
                end else if (mem_resp) begin
                    data_resp         = 1'b1;
                    data_rdata        = mem_rdata;
                    last_served_nxt_s = REQ_DATA;
                    state_nxt_s       = IDLE;
                end else if (expired_s) begin
                    data_resp         = 1'b1;
                    set_err_s         = 1'b1;
                    last_served_nxt_s = REQ_DATA;
                    state_nxt_s       = IDLE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (watchdog limit set to 4).
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_read;
    logic [31:0] inst_address;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_wmask;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        timeout_err;

    int checks;
    int errors;

    mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_read      (inst_read),
        .inst_address   (inst_address),
        .inst_rdata     (inst_rdata),
        .inst_resp      (inst_resp),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_wmask     (data_wmask),
        .data_address   (data_address),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata),
        .data_resp      (data_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs checked mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        inst_read    = 1'b0;
        inst_address = 32'h0;
        data_read    = 1'b0;
        data_write   = 1'b0;
        data_wmask   = 4'b0000;
        data_address = 32'h0;
        data_wdata   = 32'h0;
        mem_rdata    = 32'h0;
        mem_resp     = 1'b0;

        // Reset state
        settle();
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        step();
        rst_n = 1'b1;

        // Fetch only, one wait state
        inst_read = 1'b1; inst_address = 32'h60;
        settle();
        check("f_idle_read", {31'd0, mem_read}, 32'd0);
        step();
        settle();
        check("f_c1_read", {31'd0, mem_read}, 32'd1);
        check("f_c1_addr", mem_address, 32'h60);
        check("f_c1_resp", {31'd0, inst_resp}, 32'd0);
        step();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        settle();
        check("f_c2_resp", {31'd0, inst_resp}, 32'd1);
        check("f_c2_rdata", inst_rdata, 32'h0000_0013);
        check("f_c2_drdata", data_rdata, 32'h0);
        step();
        inst_read = 1'b0; mem_resp = 1'b0;
        settle();
        check("f_c3_resp", {31'd0, inst_resp}, 32'd0);
        check("f_c3_read", {31'd0, mem_read}, 32'd0);

        // Tie from reset goes to data, then alternation
        do_reset();
        inst_read = 1'b1; inst_address = 32'h60;
        data_read = 1'b1; data_address = 32'h200;
        step();
        mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        check("t1_addr", mem_address, 32'h200);
        check("t1_dresp", {31'd0, data_resp}, 32'd1);
        check("t1_drdata", data_rdata, 32'h1111_1111);
        check("t1_iresp", {31'd0, inst_resp}, 32'd0);
        step();
        mem_resp = 1'b0; data_address = 32'h204;
        settle();
        check("t2_idle_read", {31'd0, mem_read}, 32'd0);
        check("t2_idle_dresp", {31'd0, data_resp}, 32'd0);
        step();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        settle();
        check("t3_addr", mem_address, 32'h60);
        check("t3_iresp", {31'd0, inst_resp}, 32'd1);
        check("t3_dresp", {31'd0, data_resp}, 32'd0);
        step();
        inst_read = 1'b0; mem_resp = 1'b0;
        settle();
        check("t4_idle_read", {31'd0, mem_read}, 32'd0);
        step();
        mem_resp = 1'b1; mem_rdata = 32'h2222_2222;
        settle();
        check("t5_addr", mem_address, 32'h204);
        check("t5_drdata", data_rdata, 32'h2222_2222);
        step();
        data_read = 1'b0; mem_resp = 1'b0;
        step();

        // Store with read also raised: treated as a write
        data_write = 1'b1; data_read = 1'b1; data_wmask = 4'b0011;
        data_address = 32'h100; data_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h0;
        step();
        settle();
        check("s_write", {31'd0, mem_write}, 32'd1);
        check("s_read", {31'd0, mem_read}, 32'd0);
        check("s_be", {28'd0, mem_byte_enable}, 32'h3);
        check("s_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("s_addr", mem_address, 32'h100);
        check("s_early_resp", {31'd0, data_resp}, 32'd0);
        step();
        mem_resp = 1'b1;
        settle();
        check("s_resp", {31'd0, data_resp}, 32'd1);
        step();
        data_write = 1'b0; data_read = 1'b0; mem_resp = 1'b0;
        settle();
        check("s_single_resp", {31'd0, data_resp}, 32'd0);
        check("s_idle_write", {31'd0, mem_write}, 32'd0);
        step();

        // Watchdog expiry on the fifth granted cycle (count reaches 4)
        inst_read = 1'b1; inst_address = 32'h80; mem_rdata = 32'hFFFF_FFFF;
        step();
        for (int i = 1; i <= 4; i++) begin
            settle();
            check("w_wait_resp", {31'd0, inst_resp}, 32'd0);
            check("w_wait_err", {31'd0, timeout_err}, 32'd0);
            step();
        end
        settle();
        check("w_resp", {31'd0, inst_resp}, 32'd1);
        check("w_rdata", inst_rdata, 32'h0);
        step();
        inst_read = 1'b0;
        settle();
        check("w_err_set", {31'd0, timeout_err}, 32'd1);
        check("w_idle_read", {31'd0, mem_read}, 32'd0);
        data_read = 1'b1; data_address = 32'h300;
        step();
        mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
        settle();
        check("w_load_resp", {31'd0, data_resp}, 32'd1);
        check("w_load_rdata", data_rdata, 32'h1234_5678);
        step();
        data_read = 1'b0; mem_resp = 1'b0;
        step();
        settle();
        check("w_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Asynchronous reset in the middle of a data grant
        data_read = 1'b1; data_address = 32'h400;
        step();
        settle();
        check("r_pre_read", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        settle();
        check("r_read", {31'd0, mem_read}, 32'd0);
        check("r_addr", mem_address, 32'h0);
        check("r_err", {31'd0, timeout_err}, 32'd0);
        step();
        rst_n = 1'b1; inst_read = 1'b1; inst_address = 32'h500;
        mem_resp = 1'b1; mem_rdata = 32'hABCD_0000;
        settle();
        check("r_stale_dresp", {31'd0, data_resp}, 32'd0);
        check("r_stale_iresp", {31'd0, inst_resp}, 32'd0);
        step();
        mem_resp = 1'b0;
        settle();
        check("r_tie_addr", mem_address, 32'h400);
        step();
        mem_resp = 1'b1;
        settle();
        check("r_dresp", {31'd0, data_resp}, 32'd1);
        step();
        data_read = 1'b0; inst_read = 1'b0; mem_resp = 1'b0;
        step();

        // Fetch withdrawn mid-grant; fairness pointer must stay at data
        inst_read = 1'b1; inst_address = 32'h500;
        step();
        settle();
        check("a_read", {31'd0, mem_read}, 32'd1);
        step();
        inst_read = 1'b0;
        settle();
        check("a_drop_read", {31'd0, mem_read}, 32'd1);
        check("a_drop_resp", {31'd0, inst_resp}, 32'd0);
        step();
        settle();
        check("a_idle_read", {31'd0, mem_read}, 32'd0);
        check("a_idle_resp", {31'd0, inst_resp}, 32'd0);
        inst_read = 1'b1; data_read = 1'b1; data_address = 32'h600;
        step();
        settle();
        check("a_tie_addr", mem_address, 32'h500);
        mem_resp = 1'b1; mem_rdata = 32'h0000_0055;
        settle();
        check("a_iresp", {31'd0, inst_resp}, 32'd1);
        step();
        inst_read = 1'b0; data_read = 1'b0; mem_resp = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single magic-memory port between instruction fetch and data (load/store) access of the RV32I core. Both requester ports and the memory port use the core's level-held read/write plus single-cycle `resp` handshake. Ties are resolved by alternation. A watchdog terminates any grant that waits too long for `mem_resp`, so a wedged memory cannot hang the core.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum granted cycles without `mem_resp` before forced completion; legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_read` in 1: fetch request, held until `inst_resp`.
- `inst_address` in 32: fetch address, stable while `inst_read`.
- `inst_rdata` out 32: fetch data, valid with `inst_resp`.
- `inst_resp` out 1: one-cycle completion pulse to fetch.
- `data_read` in 1: load request, held until `data_resp`.
- `data_write` in 1: store request, held until `data_resp`.
- `data_wmask` in 4: store byte enables.
- `data_address` in 32: load/store address.
- `data_wdata` in 32: store data.
- `data_rdata` out 32: load data, valid with `data_resp`.
- `data_resp` out 1: one-cycle completion pulse to data side.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_byte_enable` out 4: memory write mask.
- `mem_address` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.
- `mem_resp` in 1: memory completion.
- `timeout_err` out 1: sticky flag; set on any watchdog expiry.

## Operation
- FSM states: IDLE, INST, DATA.
- IDLE:
  - Only `inst_read` pending → INST.
  - Only data request pending → DATA.
  - Both pending → grant the requester not served last. The `last_served` register resets to INST, so the first tie goes to data.
  - Neither pending → stay in IDLE.
- INST:
  - `mem_read`=1; `mem_address`=`inst_address`; `mem_write`=0.
- DATA:
  - `mem_read`=`data_read & ~data_write`; `mem_write`=`data_write`; `mem_byte_enable`=`data_wmask`.
  - `mem_address`=`data_address`; `mem_wdata`=`data_wdata`.
  - Read and write asserted together is treated as a write.
- Completion:
  - In INST/DATA, `mem_resp`=1 → same-cycle resp pulse to the granted requester.
  - Granted `*_rdata` = `mem_rdata`.
  - `last_served` updates to the granted requester; next state IDLE.
- Non-granted outputs: `*_resp`=0 and `*_rdata`=0 at all times.
- In IDLE, all `mem_*` outputs are 0.
- Abort: if the granted request deasserts before `mem_resp`, return to IDLE next cycle. No resp is issued and `last_served` is unchanged.
- Watchdog:
  - 16-bit counter clears on every grant entry and increments each granted cycle without `mem_resp`.
  - When count reaches `TIMEOUT_CYCLES`, that cycle: pulse the requester's resp with rdata 32'h0, set `timeout_err`, go to IDLE, update `last_served`.
  - `timeout_err` clears only on reset.
- Reset (asynchronous, any state, including mid-transaction): state IDLE, `last_served`=INST, counter 0, `timeout_err`=0, all outputs 0. An in-flight transaction is dropped silently.

## Timing
- Request sampled at edge N (IDLE) → memory strobes asserted in cycle N+1.
- Resp is combinational from `mem_resp`. With zero-wait memory, the requester sees resp in cycle N+1, giving 2-cycle request-to-resp.
- Exactly one idle cycle follows every completion. Back-to-back grants therefore alternate at one transaction per (memory latency + 2) cycles.
- Only one resp pulse per grant. A requester still asserting its request in the cycle after resp is treated as a new request.
- Simultaneous requests arriving in the completion cycle are evaluated in the following IDLE cycle.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, INST, DATA}.
  - `requester_t` enum {REQ_INST, REQ_DATA}.
  - `TIMEOUT_W`=16 counter-width constant.
- Sub-module `arb_watchdog`:
  - Inputs: `clk`, `rst_n`, `clear`, `enable`.
  - Output: `expired` (counter equals `TIMEOUT_CYCLES`).
  - Instantiated once.
- Muxing and FSM live in `mem_arbiter`.

## Test plan
- Fetch only, addr 32'h60, memory returns 32'h00000013 at 1 wait state → `mem_read` in cycle 1, `inst_resp` in cycle 2 with `inst_rdata`=32'h00000013.
- Fetch and load both raised in cycle 0 from reset → DATA granted first, then INST after one idle cycle. A second simultaneous pair → INST first (alternation).
- Store 32'hDEADBEEF, mask 4'b0011, addr 32'h100 → `mem_write`=1, `mem_byte_enable`=4'b0011, `mem_wdata` matches; `mem_read`=0; single `data_resp`.
- `TIMEOUT_CYCLES`=4, memory never responds → `inst_resp` after 4 granted cycles with rdata 0; `timeout_err`=1 and remains 1; a subsequent load completes normally.
- `rst_n` low during DATA grant with memory busy → all outputs 0 immediately. After release, the stale `mem_resp` produces no resp, and the next tie grants DATA.
- Fetch request dropped mid-grant → FSM returns to IDLE, no `inst_resp`, `mem_read` deasserts one cycle later.
